// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell (two half adders plus an OR) processes
// one operand bit per clock, LSB first, with the carry held in a flip-flop.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [1:0]       ha0;
    logic [1:0]       ha1;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    // Returns {carry, sum} of a 1-bit half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    always_comb begin
        ha0   = half_add(a_sr[0], b_sr[0]);
        ha1   = half_add(ha0[0], carry);
        bit_s = ha1[0];
        bit_c = ha0[1] | ha1[1];
    end

    // New sum bits enter at the MSB end so the LSB lands in bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_next = bit_s;
        end else begin : g_wn
            assign res_next = {bit_s, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= opA;
                        b_sr   <= opB;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry  <= bit_c;
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
